// File: rtl/sr_flag_arbiter.sv
// Bank of NFLAG SR flags shared by NREQ requesters; a round-robin arbiter
// serialises {s,r} commands and applies one every IDLE->GRANT->APPLY pass.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      cmd,
    input  logic [IDXW*NREQ-1:0]   idx,
    output logic [NREQ-1:0]        gnt,
    output logic                   ack,
    output logic                   err,
    output logic                   busy,
    output logic [NFLAG-1:0]       q,
    output logic [NFLAG-1:0]       qb
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NIDX = 1 << IDXW;

    // Legal-index lookup; avoids a range compare that is constant when NFLAG == 2**IDXW.
    function automatic logic [NIDX-1:0] idx_ok_mask();
        logic [NIDX-1:0] m;
        m = '0;
        for (int i = 0; i < NIDX; i++) m[i] = (i < NFLAG);
        return m;
    endfunction
    localparam logic [NIDX-1:0] IDX_OK = idx_ok_mask();

    typedef enum logic [1:0] {IDLE, GRANT, APPLY} state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q, win_q, win_d;
    logic [1:0]        cmd_q;
    logic [IDXW-1:0]   idx_q;
    logic [NREQ-1:0]   gnt_q;
    logic              ack_q, err_q;
    logic [NFLAG-1:0]  q_q, hit_d;
    logic              bad_d;

    // Descending scan so the requester closest to ptr (k smallest) wins last.
    always_comb begin
        int j;
        j     = 0;
        win_d = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) win_d = j[PW-1:0];
        end
    end

    always_comb begin
        bad_d = (cmd_q == 2'b11) || !IDX_OK[idx_q];
        hit_d = {{(NFLAG-1){1'b0}}, 1'b1} << idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cmd_q   <= 2'b00;
            idx_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            q_q     <= '0;
        end else begin
            gnt_q <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        win_q   <= win_d;
                        cmd_q   <= cmd[2*win_d +: 2];
                        idx_q   <= idx[IDXW*win_d +: IDXW];
                        gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << win_d;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    ack_q   <= 1'b1;
                    err_q   <= bad_d;
                    state_q <= APPLY;
                end
                APPLY: begin
                    if (!bad_d && cmd_q != 2'b00)
                        q_q <= cmd_q[1] ? (q_q | hit_d) : (q_q & ~hit_d);
                    ptr_q   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);
    assign q    = q_q;
    assign qb   = ~q_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: main instance (NFLAG=8) plus a NFLAG=6
// instance for out-of-range indices.
module tb_sr_flag_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [7:0]  cmd = '0;
    logic [11:0] idx = '0;
    logic [3:0]  gnt;
    logic        ack, err, busy;
    logic [7:0]  q, qb;

    logic [3:0]  req6 = '0;
    logic [7:0]  cmd6 = '0;
    logic [11:0] idx6 = '0;
    logic [3:0]  gnt6;
    logic        ack6, err6, busy6;
    logic [5:0]  q6, qb6;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .idx(idx),
        .gnt(gnt), .ack(ack), .err(err), .busy(busy), .q(q), .qb(qb)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .req(req6), .cmd(cmd6), .idx(idx6),
        .gnt(gnt6), .ack(ack6), .err(err6), .busy(busy6), .q(q6), .qb(qb6)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int r, input logic [1:0] c, input logic [2:0] i);
        req[r]        = 1'b1;
        cmd[2*r +: 2] = c;
        idx[3*r +: 3] = i;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt got %b want 0000", gnt); end
        n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL rst_q got %h want 00", q); end
        n_cmp++; if (qb !== 8'hFF) begin n_bad++; $display("FAIL rst_qb got %h want FF", qb); end
        n_cmp++; if ({ack, err, busy} !== 3'b000) begin n_bad++; $display("FAIL rst_ack_err_busy got %b want 000", {ack, err, busy}); end
        rst_n = 1'b1;
        tick();
        drive(0, 2'b10, 3'd1);
        tick();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL pre_abort_gnt got %b want 0001", gnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL abort_gnt got %b want 0000", gnt); end
        n_cmp++; if (q !== 8'h00 || qb !== 8'hFF) begin n_bad++; $display("FAIL abort_q got %h/%h want 00/FF", q, qb); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rearb_gnt got %b want 0001", gnt); end
        req = '0;
        tick();
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rearb_ack got %b want 1", ack); end
        tick();
        n_cmp++; if (q !== 8'h02 || busy !== 1'b0) begin n_bad++; $display("FAIL rearb_q got %h busy %b want 02 busy 0", q, busy); end
    endtask

    // Starts from q=02, ptr=1.
    task automatic test_set_reset();
        drive(1, 2'b10, 3'd5);
        tick();
        n_cmp++; if (gnt !== 4'b0010 || ack !== 1'b0) begin n_bad++; $display("FAIL set_gnt got %b ack %b want 0010 ack 0", gnt, ack); end
        req = '0;
        tick();
        n_cmp++; if (ack !== 1'b1 || err !== 1'b0 || gnt !== 4'b0000) begin n_bad++; $display("FAIL set_ack got ack %b err %b gnt %b want 1 0 0000", ack, err, gnt); end
        tick();
        n_cmp++; if (q !== 8'h22 || qb !== 8'hDD) begin n_bad++; $display("FAIL set_q got %h/%h want 22/DD", q, qb); end
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL set_ack_pulse got %b want 0", ack); end
        drive(1, 2'b01, 3'd5);
        tick();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL clr_gnt got %b want 0010", gnt); end
        req = '0;
        tick(); tick();
        n_cmp++; if (q !== 8'h02 || qb !== 8'hFD) begin n_bad++; $display("FAIL clr_q got %h/%h want 02/FD", q, qb); end
    endtask

    task automatic test_round_robin();
        int acks;
        logic [3:0] exp;
        acks = 0;
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        req = 4'b1111; cmd = '0; idx = '0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            exp = 4'b0000;
            if (c % 3 == 1) exp = 4'b0001 << (((c - 1) / 3) % 4);
            n_cmp++; if (gnt !== exp) begin n_bad++; $display("FAIL rr_gnt c=%0d got %b want %b", c, gnt, exp); end
            if (ack === 1'b1) acks++;
            if (c == 13) req = '0;
        end
        n_cmp++; if (acks != 5) begin n_bad++; $display("FAIL rr_acks got %0d want 5", acks); end
        n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL rr_q got %h want 00", q); end
    endtask

    // ptr=1 after round-robin; req2 wins both passes.
    task automatic test_forbidden();
        drive(2, 2'b10, 3'd3);
        tick(); req = '0;
        tick(); tick();
        n_cmp++; if (q !== 8'h08) begin n_bad++; $display("FAIL fb_setup_q got %h want 08", q); end
        drive(2, 2'b11, 3'd3);
        tick();
        n_cmp++; if (gnt !== 4'b0100 || err !== 1'b0) begin n_bad++; $display("FAIL fb_gnt got %b err %b want 0100 err 0", gnt, err); end
        req = '0;
        tick();
        n_cmp++; if (ack !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL fb_err got ack %b err %b want 1 1", ack, err); end
        tick();
        n_cmp++; if (q !== 8'h08 || qb !== 8'hF7) begin n_bad++; $display("FAIL fb_q got %h/%h want 08/F7", q, qb); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL fb_err_pulse got %b want 0", err); end
    endtask

    task automatic test_out_of_range();
        logic [2:0] ix [3];
        logic       xe [3];
        logic [5:0] xq [3];
        ix = '{3'd7, 3'd5, 3'd6};
        xe = '{1'b1, 1'b0, 1'b1};
        xq = '{6'h00, 6'h20, 6'h20};
        for (int t = 0; t < 3; t++) begin
            req6 = 4'b0001; cmd6[1:0] = 2'b10; idx6[2:0] = ix[t];
            tick();
            n_cmp++; if (gnt6 !== 4'b0001) begin n_bad++; $display("FAIL oor_gnt t=%0d got %b want 0001", t, gnt6); end
            req6 = '0;
            tick();
            n_cmp++; if (ack6 !== 1'b1 || err6 !== xe[t]) begin n_bad++; $display("FAIL oor_err t=%0d got ack %b err %b want 1 %b", t, ack6, err6, xe[t]); end
            tick();
            n_cmp++; if (q6 !== xq[t] || qb6 !== ~xq[t]) begin n_bad++; $display("FAIL oor_q t=%0d got %h/%h want %h/%h", t, q6, qb6, xq[t], ~xq[t]); end
        end
    endtask

    // ptr=3 after test_forbidden: req3 (reset) is applied before req0 (set).
    task automatic test_back_to_back();
        drive(0, 2'b10, 3'd0);
        drive(3, 2'b01, 3'd0);
        tick();
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL b2b_gnt1 got %b want 1000", gnt); end
        req[3] = 1'b0;
        tick(); tick();
        n_cmp++; if (q !== 8'h08) begin n_bad++; $display("FAIL b2b_q1 got %h want 08", q); end
        tick();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL b2b_gnt2 got %b want 0001", gnt); end
        req = '0;
        tick(); tick();
        n_cmp++; if (q !== 8'h09 || qb !== 8'hF6) begin n_bad++; $display("FAIL b2b_q2 got %h/%h want 09/F6", q, qb); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_set_reset();
        test_round_robin();
        test_forbidden();
        test_out_of_range();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end

endmodule
